// File: rtl/lfsr_gen_if.sv
// Control/observe bundle between the LFSR pattern source and its controller.
// master drives step/seed controls; slave (lfsr_gen) returns pattern and status.
interface lfsr_gen_if #(
    parameter int WIDTH = 12
);
    logic             en;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             lfsr_ouptut;
    logic             max_tick_reg;
    logic [WIDTH-1:0] lfsr_state;
    logic [WIDTH-1:0] period_cnt;
    logic             lockup_err;

    modport master (
        output en, seed_load, seed_in,
        input  lfsr_ouptut, max_tick_reg, lfsr_state, period_cnt, lockup_err
    );

    modport slave (
        input  en, seed_load, seed_in,
        output lfsr_ouptut, max_tick_reg, lfsr_state, period_cnt, lockup_err
    );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR pattern source with period tick, seed load and zero-seed guard; 1-cycle latency.
// No backpressure: en gates stepping, all outputs hold while en=0 (tick drops to 0).
module lfsr_gen #(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] TAPS  = 12'h829,
    parameter logic [WIDTH-1:0] SEED  = 12'h001
) (
    input  logic      clk,
    input  logic      rst,
    lfsr_gen_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] start_reg;
    logic [WIDTH-1:0] cnt;
    logic             tick;
    logic             lock_err;
    logic             fb;
    logic [WIDTH-1:0] next_state;
    logic             wrap;

    always_comb begin
        fb         = ^(state & TAPS);
        next_state = {state[WIDTH-2:0], fb};
        wrap       = (next_state == start_reg);
    end

    // Load beats step; a zero seed falls back to SEED so the register never locks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEED;
            start_reg <= SEED;
            cnt       <= '0;
            tick      <= 1'b0;
            lock_err  <= 1'b0;
        end else if (bus.seed_load) begin
            if (bus.seed_in != '0) begin
                state     <= bus.seed_in;
                start_reg <= bus.seed_in;
                lock_err  <= 1'b0;
            end else begin
                state     <= SEED;
                start_reg <= SEED;
                lock_err  <= 1'b1;
            end
            cnt  <= '0;
            tick <= 1'b0;
        end else if (bus.en) begin
            state <= next_state;
            if (wrap) begin
                tick <= 1'b1;
                cnt  <= '0;
            end else begin
                tick <= 1'b0;
                cnt  <= cnt + ONE;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    assign bus.lfsr_ouptut  = state[WIDTH-1];
    assign bus.lfsr_state   = state;
    assign bus.period_cnt   = cnt;
    assign bus.max_tick_reg = tick;
    assign bus.lockup_err   = lock_err;
endmodule

// File: tb/tb_lfsr_gen.sv
// Directed checks of lfsr_gen: reset, stepping, period tick, hold, seed load priority, async reset.
module tb_lfsr_gen;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   nticks;
    logic [11:0] m;

    lfsr_gen_if #(.WIDTH(12)) bus ();

    lfsr_gen #(.WIDTH(12), .TAPS(12'h829), .SEED(12'h001)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x^12+x^6+x^4+x+1 : feedback from bits 11,5,3,0
    function automatic logic [11:0] nxt(input logic [11:0] s);
        return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            m = nxt(m);
            if (bus.max_tick_reg) nticks++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nticks = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed_in = 12'h000;
        #12;
        chk("rst_state", {20'd0, bus.lfsr_state}, 32'h001);
        chk("rst_cnt", {20'd0, bus.period_cnt}, 32'h0);
        chk("rst_tick", {31'd0, bus.max_tick_reg}, 32'h0);
        chk("rst_lock", {31'd0, bus.lockup_err}, 32'h0);
        chk("rst_out", {31'd0, bus.lfsr_ouptut}, 32'h0);

        // first four steps
        @(negedge clk);
        rst = 1'b0;
        bus.en = 1'b1;
        tick(); chk("step1", {20'd0, bus.lfsr_state}, 32'h003);
        tick(); chk("step2", {20'd0, bus.lfsr_state}, 32'h007);
        tick(); chk("step3", {20'd0, bus.lfsr_state}, 32'h00F);
        tick(); chk("step4", {20'd0, bus.lfsr_state}, 32'h01E);
        chk("step4_out", {31'd0, bus.lfsr_ouptut}, 32'h0);
        chk("step4_cnt", {20'd0, bus.period_cnt}, 32'd4);

        // full period from reset
        m = 12'h01E;
        nticks = 0;
        run(4090);
        chk("p4094_ticks", nticks, 0);
        chk("p4094_tick", {31'd0, bus.max_tick_reg}, 32'h0);
        chk("p4094_state", {20'd0, bus.lfsr_state}, {20'd0, m});
        chk("p4094_cnt", {20'd0, bus.period_cnt}, 32'd4094);
        tick();
        chk("p4095_tick", {31'd0, bus.max_tick_reg}, 32'h1);
        chk("p4095_state", {20'd0, bus.lfsr_state}, 32'h001);
        chk("p4095_cnt", {20'd0, bus.period_cnt}, 32'h0);
        tick();
        chk("p4096_tick", {31'd0, bus.max_tick_reg}, 32'h0);
        chk("p4096_state", {20'd0, bus.lfsr_state}, 32'h003);
        chk("p4096_cnt", {20'd0, bus.period_cnt}, 32'd1);

        // hold mid-run for 10 cycles
        m = 12'h003;
        run(9);
        bus.en = 1'b0;
        nticks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.max_tick_reg) nticks++;
        end
        chk("hold_ticks", nticks, 0);
        chk("hold_state", {20'd0, bus.lfsr_state}, {20'd0, m});
        chk("hold_cnt", {20'd0, bus.period_cnt}, 32'd10);
        chk("hold_out", {31'd0, bus.lfsr_ouptut}, {31'd0, m[11]});
        bus.en = 1'b1;
        nticks = 0;
        run(4084);
        chk("resume_ticks", nticks, 0);
        chk("resume_cnt", {20'd0, bus.period_cnt}, 32'd4094);
        tick();
        chk("resume_tick", {31'd0, bus.max_tick_reg}, 32'h1);
        chk("resume_state", {20'd0, bus.lfsr_state}, 32'h001);

        // zero seed rejected, then a valid seed
        bus.seed_load = 1'b1;
        bus.seed_in = 12'h000;
        tick();
        chk("zload_lock", {31'd0, bus.lockup_err}, 32'h1);
        chk("zload_state", {20'd0, bus.lfsr_state}, 32'h001);
        chk("zload_cnt", {20'd0, bus.period_cnt}, 32'h0);
        bus.seed_in = 12'hABC;
        tick();
        bus.seed_load = 1'b0;
        chk("abc_lock", {31'd0, bus.lockup_err}, 32'h0);
        chk("abc_state", {20'd0, bus.lfsr_state}, 32'hABC);
        chk("abc_out", {31'd0, bus.lfsr_ouptut}, 32'h1);
        m = 12'hABC;
        nticks = 0;
        run(4094);
        chk("abc_ticks", nticks, 0);
        tick();
        chk("abc_tick", {31'd0, bus.max_tick_reg}, 32'h1);
        chk("abc_wrap_state", {20'd0, bus.lfsr_state}, 32'hABC);

        // load together with en
        bus.seed_load = 1'b1;
        bus.seed_in = 12'h555;
        tick();
        bus.seed_load = 1'b0;
        chk("ld_en_state", {20'd0, bus.lfsr_state}, 32'h555);
        chk("ld_en_cnt", {20'd0, bus.period_cnt}, 32'h0);

        // load on the would-be wrap step suppresses the tick
        m = 12'h555;
        nticks = 0;
        run(4094);
        chk("prewrap_ticks", nticks, 0);
        chk("prewrap_state", {20'd0, bus.lfsr_state}, {20'd0, m});
        bus.seed_load = 1'b1;
        bus.seed_in = 12'h123;
        tick();
        bus.seed_load = 1'b0;
        chk("wrapld_tick", {31'd0, bus.max_tick_reg}, 32'h0);
        chk("wrapld_state", {20'd0, bus.lfsr_state}, 32'h123);
        chk("wrapld_cnt", {20'd0, bus.period_cnt}, 32'h0);

        // async reset at step 100 with lockup_err set
        bus.seed_load = 1'b1;
        bus.seed_in = 12'h000;
        tick();
        bus.seed_load = 1'b0;
        m = 12'h001;
        run(100);
        chk("s100_state", {20'd0, bus.lfsr_state}, {20'd0, m});
        chk("s100_cnt", {20'd0, bus.period_cnt}, 32'd100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_state", {20'd0, bus.lfsr_state}, 32'h001);
        chk("arst_cnt", {20'd0, bus.period_cnt}, 32'h0);
        chk("arst_lock", {31'd0, bus.lockup_err}, 32'h0);
        chk("arst_tick", {31'd0, bus.max_tick_reg}, 32'h0);
        chk("arst_out", {31'd0, bus.lfsr_ouptut}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick(); chk("post1", {20'd0, bus.lfsr_state}, 32'h003);
        tick(); chk("post2", {20'd0, bus.lfsr_state}, 32'h007);
        tick(); chk("post3", {20'd0, bus.lfsr_state}, 32'h00F);
        tick(); chk("post4", {20'd0, bus.lfsr_state}, 32'h01E);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
